mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 32-bit system RAM between the picorv32 native memory interface (master 0) and an auxiliary bus master (master 1, e.g. a PS/2 keycode logger or DMA writer).
- Sequences every access through a fixed three-phase IDLE/ACCESS/RESP cycle.
- Decodes out-of-range addresses and flags them.
- Sits between the requesters and the memory array in system.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master system RAM arbiter.
package mem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request winner selection: round robin on last_grant, or strict
// master-0 priority when prio_m0 is set.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic prio_m0,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = GRANT_M0;
        if (req0 && req1) begin
            gnt_id = prio_m0 ? GRANT_M0 : ~last_grant;
        end else if (req1) begin
            gnt_id = GRANT_M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port system RAM, fixed IDLE/ACCESS/RESP
// sequence. Define MEM_ARB_M0_PRIORITY_EN for strict master-0 priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         m0_valid,
    input  logic [ADDR_W-1:0]            m0_addr,
    input  logic [DATA_W-1:0]            m0_wdata,
    input  logic [3:0]                   m0_wstrb,
    output logic                         m0_ready,
    output logic [DATA_W-1:0]            m0_rdata,

    input  logic                         m1_valid,
    input  logic [ADDR_W-1:0]            m1_addr,
    input  logic [DATA_W-1:0]            m1_wdata,
    input  logic [3:0]                   m1_wstrb,
    output logic                         m1_ready,
    output logic [DATA_W-1:0]            m1_rdata,

    output logic                         ram_en,
    output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic [3:0]                   ram_wstrb,
    input  logic [DATA_W-1:0]            ram_rdata,

    output logic                         err
);

    localparam int                AW          = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);

`ifdef MEM_ARB_M0_PRIORITY_EN
    localparam logic PRIO_M0 = 1'b1;
`else
    localparam logic PRIO_M0 = 1'b0;
`endif

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              in_range_q, in_range_d;
    logic              is_read_q, is_read_d;
    logic              ram_en_q, ram_en_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_wstrb_q, ram_wstrb_d;
    logic              err_q, err_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              sel_in_range;
    logic [DATA_W-1:0] resp_data;

    // Byte-offset bits never reach the word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    rr_arbiter2 u_arb (
        .req0       (m0_valid),
        .req1       (m1_valid),
        .last_grant (last_grant_q),
        .prio_m0    (PRIO_M0),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        sel_addr     = (gnt_id == GRANT_M1) ? m1_addr  : m0_addr;
        sel_wdata    = (gnt_id == GRANT_M1) ? m1_wdata : m0_wdata;
        sel_wstrb    = (gnt_id == GRANT_M1) ? m1_wstrb : m0_wstrb;
        sel_in_range = ({2'b00, sel_addr[ADDR_W-1:2]} < MEM_WORDS_L);
        resp_data    = (in_range_q && is_read_q) ? ram_rdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        in_range_d   = in_range_q;
        is_read_d    = is_read_q;
        ram_en_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wstrb_d  = ram_wstrb_q;
        err_d        = err_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = '0;
        m1_rdata_d   = '0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d      = gnt_id;
                    last_grant_d = gnt_id;
                    ram_addr_d   = sel_addr[AW+1:2];
                    ram_wdata_d  = sel_wdata;
                    ram_wstrb_d  = sel_wstrb;
                    is_read_d    = (sel_wstrb == 4'b0000);
                    in_range_d   = sel_in_range;
                    if (sel_in_range) begin
                        ram_en_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // RAM read data lands in this cycle; register it with the ready pulse.
                if (grant_q == GRANT_M1) begin
                    m1_ready_d = 1'b1;
                    m1_rdata_d = resp_data;
                end else begin
                    m0_ready_d = 1'b1;
                    m0_rdata_d = resp_data;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_M1;
            grant_q      <= GRANT_M0;
            in_range_q   <= 1'b0;
            is_read_q    <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wstrb_q  <= '0;
            err_q        <= 1'b0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            in_range_q   <= in_range_d;
            is_read_q    <= is_read_d;
            ram_en_q     <= ram_en_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wstrb_q  <= ram_wstrb_d;
            err_q        <= err_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_ready  = m0_ready_q;
    assign m1_ready  = m1_ready_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wstrb = ram_wstrb_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// Honours MEM_ARB_M0_PRIORITY_EN when the design is built with it.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        err;

    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MEM_ARB_M0_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    mem_arbiter #(.MEM_WORDS(4096), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_valid  (m0_valid),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wstrb (ram_wstrb),
        .ram_rdata (ram_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM with per-byte write enables and a bench preload port.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    function automatic logic rdy(input logic m);
        return m ? m1_ready : m0_ready;
    endfunction

    function automatic logic [31:0] rdat(input logic m);
        return m ? m1_rdata : m0_rdata;
    endfunction

    // One transaction from an idle arbiter; valid is dropped after the grant.
    task automatic do_txn(input string tag, input logic m, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic exp_en, input logic [31:0] exp_rdata);
        if (m) begin
            m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
        tick();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        check_eq({tag, ".ram_en_n1"}, {31'b0, ram_en}, {31'b0, exp_en});
        if (exp_en) begin
            check_eq({tag, ".ram_addr"},  {20'b0, ram_addr},  {20'b0, addr[13:2]});
            check_eq({tag, ".ram_wstrb"}, {28'b0, ram_wstrb}, {28'b0, wstrb});
            check_eq({tag, ".ram_wdata"}, ram_wdata, wdata);
        end
        tick();
        check_eq({tag, ".ram_en_n2"}, {31'b0, ram_en}, 32'd0);
        check_eq({tag, ".ready_n2"},  {31'b0, rdy(m)}, 32'd0);
        tick();
        check_eq({tag, ".ready_n3"},       {31'b0, rdy(m)},  32'd1);
        check_eq({tag, ".rdata_n3"},       rdat(m),          exp_rdata);
        check_eq({tag, ".other_ready_n3"}, {31'b0, rdy(!m)}, 32'd0);
        check_eq({tag, ".other_rdata_n3"}, rdat(!m),         32'd0);
        tick();
        check_eq({tag, ".ready_n4"}, {31'b0, rdy(m)}, 32'd0);
    endtask

    initial begin
        logic [3:0]  exp_g;
        logic [31:0] exp_d0, exp_d1;
        int          slot;
        int          n_rdy, n_en;

        reset    = 1'b1;
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst.outs", {m0_ready, m1_ready, ram_en, err, ram_wstrb, 24'b0}, 32'd0);
        check_eq("rst.m0_rdata",  m0_rdata,  32'd0);
        check_eq("rst.m1_rdata",  m1_rdata,  32'd0);
        check_eq("rst.ram_addr",  {20'b0, ram_addr}, 32'd0);
        check_eq("rst.ram_wdata", ram_wdata, 32'd0);
        reset = 1'b0;

        preload(12'd5, 32'hDEADBEEF);
        preload(12'd8, 32'hAABBCCDD);

        do_txn("rd", 1'b0, 32'h14, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF);
        do_txn("bwr", 1'b1, 32'h20, 32'h11223344, 4'b0010, 1'b1, 32'h0);
        check_eq("bwr.mem8", mem[8], 32'hAABB33DD);

        // Contention: last grant was m1, so m0 wins the first tie.
        exp_g = PRIO ? 4'b0000 : 4'b1010;
        m0_valid = 1'b1; m0_addr = 32'h14; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = '0; m1_wstrb = '0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 10) begin
                m0_valid = 1'b0;
                m1_valid = 1'b0;
            end
            slot   = ((k % 3) == 0 && k <= 12) ? (k / 3) : 0;
            exp_d0 = (slot != 0 && !exp_g[slot-1]) ? 32'hDEADBEEF : 32'h0;
            exp_d1 = (slot != 0 &&  exp_g[slot-1]) ? 32'hAABB33DD : 32'h0;
            check_eq($sformatf("cont.m0_ready.c%0d", k), {31'b0, m0_ready}, {31'b0, exp_d0 != 0});
            check_eq($sformatf("cont.m1_ready.c%0d", k), {31'b0, m1_ready}, {31'b0, exp_d1 != 0});
            check_eq($sformatf("cont.m0_rdata.c%0d", k), m0_rdata, exp_d0);
            check_eq($sformatf("cont.m1_rdata.c%0d", k), m1_rdata, exp_d1);
        end

        do_txn("top", 1'b1, 32'h3FFC, 32'hCAFEF00D, 4'b1111, 1'b1, 32'h0);
        check_eq("top.err", {31'b0, err}, 32'd0);
        check_eq("top.mem", mem[4095], 32'hCAFEF00D);

        do_txn("oor", 1'b0, 32'h4000, 32'h0, 4'b0000, 1'b0, 32'h0);
        check_eq("oor.err", {31'b0, err}, 32'd1);
        do_txn("rdback", 1'b0, 32'h20, 32'h0, 4'b0000, 1'b1, 32'hAABB33DD);
        check_eq("rdback.err_sticky", {31'b0, err}, 32'd1);

        // Valid dropped right after the grant: still exactly one access and one pulse.
        n_rdy = 0;
        n_en  = 0;
        m0_valid = 1'b1; m0_addr = 32'h24; m0_wdata = 32'h12345678; m0_wstrb = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) m0_valid = 1'b0;
            n_rdy += int'(m0_ready);
            n_en  += int'(ram_en);
        end
        check_eq("vdrop.ready_pulses", n_rdy, 32'd1);
        check_eq("vdrop.ram_en_cycles", n_en, 32'd1);
        check_eq("vdrop.mem9", mem[9], 32'h12345678);
        check_eq("vdrop.err_sticky", {31'b0, err}, 32'd1);

        // Reset during the ACCESS cycle of an m1 write.
        m1_valid = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h55; m1_wstrb = 4'b1111;
        tick();
        m1_valid = 1'b0;
        check_eq("rstmid.ram_en_access", {31'b0, ram_en}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rstmid.ram_en", {31'b0, ram_en}, 32'd0);
        check_eq("rstmid.err", {31'b0, err}, 32'd0);
        check_eq("rstmid.m1_ready_a", {31'b0, m1_ready}, 32'd0);
        tick();
        check_eq("rstmid.m1_ready_b", {31'b0, m1_ready}, 32'd0);
        tick();
        check_eq("rstmid.m1_ready_c", {31'b0, m1_ready}, 32'd0);
        check_eq("rstmid.ram_en_c", {31'b0, ram_en}, 32'd0);
        do_txn("postrst", 1'b0, 32'h14, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
